// File: rtl/dcache_pkg.sv
// Shared widths, FSM state codes and address-field helpers for the data cache.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 1 << INDEX_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    // Controller state encoding; kept as plain constants so older code can share it.
    typedef logic [1:0] state_t;
    localparam state_t IDLE       = 2'd0;
    localparam state_t WRITE_BACK = 2'd1;
    localparam state_t FETCH      = 2'd2;
    localparam state_t UPDATE     = 2'd3;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: sequences victim write-back and block fetch, and owns the
// registered memory handshake so mem_read/mem_write only move on a clock edge.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss,
    input  logic                  victim_dirty,
    input  logic [TAG_W-1:0]      victim_tag,
    input  logic [BLOCK_W-1:0]    victim_data,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [INDEX_W-1:0]    index,
    input  logic                  mem_busywait,
    output state_t                state,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata
);

    // State and memory-request registers; the address is held through UPDATE so
    // memory keeps presenting the fetched block while it is captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        if (victim_dirty) begin
                            state         <= WRITE_BACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {victim_tag, index};
                            mem_writedata <= victim_data;
                        end else begin
                            state       <= FETCH;
                            mem_read    <= 1'b1;
                            mem_address <= {req_tag, index};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (!mem_busywait) begin
                        state         <= FETCH;
                        mem_write     <= 1'b0;
                        mem_read      <= 1'b1;
                        mem_address   <= {req_tag, index};
                        mem_writedata <= '0;
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_address <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of data_memory.
// Holds the tag/data arrays, hit detection and byte select; misses are handed
// to dcache_ctrl.
module dcache
    import dcache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [7:0]            writedata,
    output logic [7:0]            readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [4:0]          bit_lo;
    logic                request, hit, read_hit, write_hit, update;
    state_t              state;

    assign req_tag = addr_tag(address);
    assign idx     = addr_index(address);
    assign off     = addr_offset(address);
    assign bit_lo  = {off, 3'b000};

    // read && write together is not a request at all.
    assign request   = read ^ write;
    assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
    assign read_hit  = read && !write && hit;
    assign write_hit = (state == IDLE) && write && !read && hit;
    assign update    = (state == UPDATE);

    assign readdata = read_hit ? data_q[idx][bit_lo +: 8] : 8'h00;
    // Gated by reset so the stall drops immediately even with a request held.
    assign busywait = !reset && ((state != IDLE) || (request && !hit));

    // Valid/dirty bookkeeping: a refill makes the block clean, a store hit dirties it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (update) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag/data arrays are not reset; valid bits guard their contents.
    always_ff @(posedge clock) begin
        if (update) begin
            data_q[idx] <= mem_readdata;
            tag_q[idx]  <= req_tag;
        end else if (write_hit) begin
            data_q[idx][bit_lo +: 8] <= writedata;
        end
    end

    dcache_ctrl u_ctrl (
        .clock         (clock),
        .reset         (reset),
        .miss          (request && !hit),
        .victim_dirty  (valid_q[idx] && dirty_q[idx]),
        .victim_tag    (tag_q[idx]),
        .victim_data   (data_q[idx]),
        .req_tag       (req_tag),
        .index         (idx),
        .mem_busywait  (mem_busywait),
        .state         (state),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata)
    );

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed scenarios plus randomized accesses checked against
// a flat byte-view memory model with a simple residency table.
module tb_dcache;

    logic        clock, reset, read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;

    int checks = 0;
    int errors = 0;

    // Memory responder state
    logic [31:0] mem_arr [64];
    int          mem_lat = 1;
    int          cnt;
    logic        fill_req = 1'b0;
    logic        fill_rand = 1'b0;

    // Reference model: CPU-visible bytes and which block each index holds
    logic [7:0] ref_view [256];
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [2:0] m_tag   [8];

    dcache dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_readdata = mem_arr[mem_address];
    assign mem_busywait = (mem_read || mem_write) && (cnt < mem_lat);

    // Memory: each request is busy for mem_lat cycles, then completes
    always @(posedge clock or posedge reset) begin
        if (!reset && fill_req)
            for (int i = 0; i < 64; i++) mem_arr[i] = fill_rand ? $urandom : 32'h0;
        if (reset) cnt <= 0;
        else if (mem_read || mem_write) begin
            if (cnt < mem_lat) cnt <= cnt + 1;
            else begin
                cnt <= 0;
                if (mem_write) mem_arr[mem_address] = mem_writedata;
            end
        end else cnt <= 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic fill_memory(input logic rnd);
        fill_rand = rnd;
        fill_req  = 1'b1;
        @(posedge clock); #1;
        fill_req  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; read = 1'b0; write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives one access and records what the DUT did while stalled
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, output logic [7:0] rdata,
                             output int stall, output int nwb, output int nfetch,
                             output logic [5:0] wb_addr, output logic [31:0] wb_data,
                             output logic [5:0] fetch_addr, output int first_wb,
                             output int first_fetch);
        logic to;
        @(negedge clock);
        read = rd; write = wr; address = a; writedata = d;
        #1;
        stall = 0; nwb = 0; nfetch = 0; to = 1'b0;
        wb_addr = '0; wb_data = '0; fetch_addr = '0; first_wb = -1; first_fetch = -1;
        while (busywait && !to) begin
            if (mem_write) begin
                if (first_wb < 0) first_wb = stall;
                nwb++; wb_addr = mem_address; wb_data = mem_writedata;
            end
            if (mem_read) begin
                if (first_fetch < 0) first_fetch = stall;
                nfetch++; fetch_addr = mem_address;
            end
            stall++;
            if (stall > 200) to = 1'b1;
            @(negedge clock); #1;
        end
        rdata = readdata;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL access_timeout addr=%02h busywait still %0b after %0d cycles", a, busywait, stall);
        end
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        #3;
        checks++; if (busywait !== 1'b0)      begin errors++; $display("FAIL rst_busywait got %b exp 0", busywait); end
        checks++; if (mem_read !== 1'b0)      begin errors++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
        checks++; if (mem_write !== 1'b0)     begin errors++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
        checks++; if (mem_address !== 6'h00)  begin errors++; $display("FAIL rst_mem_address got %h exp 00", mem_address); end
        checks++; if (mem_writedata !== 32'h0) begin errors++; $display("FAIL rst_mem_writedata got %h exp 0", mem_writedata); end
        checks++; if (readdata !== 8'h00)     begin errors++; $display("FAIL rst_readdata got %h exp 00", readdata); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_cold_read_miss();
        logic [7:0] rd; int st, nw, nf, fw, ff; logic [5:0] wa, fa; logic [31:0] wd;
        mem_lat = 1;
        do_access(1, 0, 8'h00, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (st != 4)      begin errors++; $display("FAIL cold_stall got %0d exp 4", st); end
        checks++; if (nf != 2)      begin errors++; $display("FAIL cold_fetch_cycles got %0d exp 2", nf); end
        checks++; if (fa !== 6'h00) begin errors++; $display("FAIL cold_fetch_addr got %h exp 00", fa); end
        checks++; if (nw != 0)      begin errors++; $display("FAIL cold_wb got %0d exp 0", nw); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL cold_rdata got %h exp 00", rd); end
    endtask

    task automatic test_write_allocate();
        logic [7:0] rd; int st, nw, nf, fw, ff; logic [5:0] wa, fa; logic [31:0] wd;
        mem_lat = 1;
        do_access(0, 1, 8'h05, 8'hAB, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (st != 4)      begin errors++; $display("FAIL wa_stall got %0d exp 4", st); end
        checks++; if (fa !== 6'h01) begin errors++; $display("FAIL wa_fetch_addr got %h exp 01", fa); end
        checks++; if (nw != 0)      begin errors++; $display("FAIL wa_wb got %0d exp 0", nw); end
        do_access(1, 0, 8'h05, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (rd !== 8'hAB) begin errors++; $display("FAIL wa_hit_rdata got %h exp AB", rd); end
        checks++; if (st != 0)      begin errors++; $display("FAIL wa_hit_stall got %0d exp 0", st); end
        checks++; if (nw + nf != 0) begin errors++; $display("FAIL wa_hit_traffic got %0d exp 0", nw + nf); end
    endtask

    task automatic test_dirty_eviction();
        logic [7:0] rd; int st, nw, nf, fw, ff; logic [5:0] wa, fa; logic [31:0] wd;
        mem_lat = 1;
        do_access(1, 0, 8'h25, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (nw != 2)             begin errors++; $display("FAIL ev_wb_cycles got %0d exp 2", nw); end
        checks++; if (wa !== 6'h01)        begin errors++; $display("FAIL ev_wb_addr got %h exp 01", wa); end
        checks++; if (wd !== 32'h0000AB00) begin errors++; $display("FAIL ev_wb_data got %h exp 0000AB00", wd); end
        checks++; if (fa !== 6'h09)        begin errors++; $display("FAIL ev_fetch_addr got %h exp 09", fa); end
        checks++; if (!(fw >= 0 && ff > fw)) begin errors++; $display("FAIL ev_order got wb@%0d fetch@%0d exp wb first", fw, ff); end
        checks++; if (st != 6)             begin errors++; $display("FAIL ev_stall got %0d exp 6", st); end
        checks++; if (rd !== 8'h00)        begin errors++; $display("FAIL ev_rdata got %h exp 00", rd); end
        do_access(1, 0, 8'h05, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (st != 4)             begin errors++; $display("FAIL ev_remiss_stall got %0d exp 4", st); end
        checks++; if (fa !== 6'h01)        begin errors++; $display("FAIL ev_remiss_addr got %h exp 01", fa); end
        checks++; if (rd !== 8'hAB)        begin errors++; $display("FAIL ev_remiss_rdata got %h exp AB", rd); end
    endtask

    task automatic test_illegal();
        logic [7:0] rd; int st, nw, nf, fw, ff; logic [5:0] wa, fa; logic [31:0] wd;
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 8'h05; writedata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || readdata !== 8'h00) begin
                errors++;
                $display("FAIL illegal_quiet cyc=%0d got bw=%b mr=%b mw=%b rd=%h exp 0 0 0 00",
                         i, busywait, mem_read, mem_write, readdata);
            end
            @(negedge clock);
        end
        read = 1'b0; write = 1'b0;
        do_access(1, 0, 8'h05, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (rd !== 8'hAB) begin errors++; $display("FAIL illegal_keep_rdata got %h exp AB", rd); end
        checks++; if (st != 0)      begin errors++; $display("FAIL illegal_keep_stall got %0d exp 0", st); end
        // The block must still be clean: evicting it writes nothing back
        do_access(1, 0, 8'h25, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (nw != 0)      begin errors++; $display("FAIL illegal_clean got %0d wb cycles exp 0", nw); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] rd; int st, nw, nf, fw, ff; logic [5:0] wa, fa; logic [31:0] wd;
        mem_lat = 3;
        @(negedge clock);
        read = 1'b1; write = 1'b0; address = 8'h45;
        for (int i = 0; i < 20 && !mem_read; i++) @(negedge clock);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL midrst_fetch_start got %b exp 1", mem_read); end
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0)     begin errors++; $display("FAIL midrst_mem_read got %b exp 0", mem_read); end
        checks++; if (busywait !== 1'b0)     begin errors++; $display("FAIL midrst_busywait got %b exp 0", busywait); end
        checks++; if (mem_address !== 6'h00) begin errors++; $display("FAIL midrst_mem_address got %h exp 00", mem_address); end
        @(negedge clock);
        reset = 1'b0; read = 1'b0;
        do_access(1, 0, 8'h00, 8'h00, rd, st, nw, nf, wa, wd, fa, fw, ff);
        checks++; if (st != 6)      begin errors++; $display("FAIL midrst_remiss_stall got %0d exp 6", st); end
        checks++; if (fa !== 6'h00) begin errors++; $display("FAIL midrst_remiss_addr got %h exp 00", fa); end
    endtask

    task automatic test_random();
        logic [7:0] rd, a, d, base, exp_rd;
        int st, nw, nf, fw, ff, exp_st, lat;
        logic [5:0] wa, fa, exp_wa, exp_fa;
        logic [31:0] wd, exp_wd;
        logic r, w, exp_wb, exp_fetch;
        logic [2:0] tg, ix;
        int op;
        fill_memory(1'b1);
        apply_reset();
        for (int i = 0; i < 256; i++) ref_view[i] = mem_arr[i >> 2][(i & 3) * 8 +: 8];
        for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; end
        for (int n = 0; n < 400; n++) begin
            tg = 3'($urandom_range(0, 2));
            ix = 3'($urandom_range(0, 7));
            a  = {tg, ix, 2'($urandom_range(0, 3))};
            d  = 8'($urandom);
            op = $urandom_range(0, 9);
            r  = (op < 5) || (op == 9);
            w  = (op >= 5);
            lat = $urandom_range(0, 3);
            mem_lat = lat;
            exp_wb = 1'b0; exp_fetch = 1'b0; exp_wa = '0; exp_wd = '0; exp_fa = {tg, ix};
            if (r ^ w) begin
                if (!(m_valid[ix] && m_tag[ix] == tg)) begin
                    if (m_valid[ix] && m_dirty[ix]) begin
                        exp_wb = 1'b1;
                        exp_wa = {m_tag[ix], ix};
                        base   = {m_tag[ix], ix, 2'b00};
                        exp_wd = {ref_view[base + 8'd3], ref_view[base + 8'd2],
                                  ref_view[base + 8'd1], ref_view[base]};
                    end
                    exp_fetch = 1'b1;
                    m_valid[ix] = 1'b1; m_tag[ix] = tg; m_dirty[ix] = 1'b0;
                end
            end
            exp_rd = (r && !w) ? ref_view[a] : 8'h00;
            exp_st = !exp_fetch ? 0 : (exp_wb ? 2 * lat + 4 : lat + 3);
            if (w && !r) begin ref_view[a] = d; m_dirty[ix] = 1'b1; end

            do_access(r, w, a, d, rd, st, nw, nf, wa, wd, fa, fw, ff);
            checks++; if (st != exp_st) begin errors++; $display("FAIL rnd_stall n=%0d a=%h rw=%b%b got %0d exp %0d", n, a, r, w, st, exp_st); end
            checks++; if (nw != (exp_wb ? lat + 1 : 0)) begin errors++; $display("FAIL rnd_wb_cycles n=%0d got %0d exp %0d", n, nw, exp_wb ? lat + 1 : 0); end
            checks++; if (nf != (exp_fetch ? lat + 1 : 0)) begin errors++; $display("FAIL rnd_fetch_cycles n=%0d got %0d exp %0d", n, nf, exp_fetch ? lat + 1 : 0); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata n=%0d a=%h got %h exp %h", n, a, rd, exp_rd); end
            if (exp_wb) begin
                checks++; if (wa !== exp_wa) begin errors++; $display("FAIL rnd_wb_addr n=%0d got %h exp %h", n, wa, exp_wa); end
                checks++; if (wd !== exp_wd) begin errors++; $display("FAIL rnd_wb_data n=%0d got %h exp %h", n, wd, exp_wd); end
            end
            if (exp_fetch) begin
                checks++; if (fa !== exp_fa) begin errors++; $display("FAIL rnd_fetch_addr n=%0d got %h exp %h", n, fa, exp_fa); end
            end
        end
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        fill_memory(1'b0);
        test_reset();
        test_cold_read_miss();
        test_write_allocate();
        test_dirty_eviction();
        test_illegal();
        test_reset_mid_fetch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache that sits between the CPU load/store path and `data_memory`. It is upstream of `data_memory` and drives that block's `read`/`write`/`address`/`writedata` handshake. Toward the CPU it serves byte-wide accesses. It stalls the CPU through `busywait` on a miss and while a dirty block is written back.

## Interface
- `ADDR_W`, 8: CPU byte address width.
- `INDEX_W`, 3: index bits; the cache holds 2^INDEX_W = 8 blocks.
- `OFFSET_W`, 2: byte-offset bits; a block is 4 bytes = 32 bits and matches one memory word.
- `TAG_W`, ADDR_W-INDEX_W-OFFSET_W = 3: tag bits.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears every valid bit, every dirty bit and the FSM.
- `read` in 1: CPU load request.
- `write` in 1: CPU store request.
- `address` in 8: CPU byte address, split as {tag[7:5], index[4:2], offset[1:0]}.
- `writedata` in 8: store byte.
- `readdata` out 8: load byte.
- `busywait` out 1: CPU stall.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `mem_address` out 6: memory block address {tag, index}.
- `mem_writedata` out 32: victim block; byte 0 is in bits [7:0].
- `mem_readdata` in 32: fetched block.
- `mem_busywait` in 1: memory busy.

## Operation
- Per-block state: `valid`, `dirty`, `tag[2:0]`, `data[31:0]`. The data array is not reset.
- Hit: `valid[index] && tag[index]==address tag`, evaluated combinationally.
- A request is `read ^ write`. `read && write` is illegal and is ignored: no access, `busywait` 0, no state change.
- Read hit: `readdata` = data[index] byte `offset`, combinational. `busywait` 0. No state change.
- Write hit: at posedge, the byte `offset` of data[index] takes `writedata` and `dirty[index]` is set to 1. `busywait` 0.
- Miss: `busywait` goes to 1 combinationally in the same cycle.
- FSM states are IDLE, WRITE_BACK, FETCH and UPDATE.
  - IDLE: on a miss, go to WRITE_BACK if `valid && dirty` for the victim, otherwise go to FETCH.
  - WRITE_BACK: `mem_write`=1, `mem_address`={victim tag, index}, `mem_writedata`=victim data. At the first posedge with `mem_busywait`==0, go to FETCH. The posedge that enters the state does not count.
  - FETCH: `mem_read`=1, `mem_address`={request tag, index}. At the first posedge with `mem_busywait`==0, go to UPDATE. The posedge that enters the state does not count.
  - UPDATE: `mem_read`=0, `mem_write`=0. At posedge, data[index] takes `mem_readdata`, tag is updated, valid=1, dirty=0, and the FSM goes to IDLE. The pending access then hits and completes as a normal hit.
- Outside the IDLE-hit case, `busywait` = (FSM != IDLE) || (request && !hit).
- CPU inputs must be held stable while `busywait`=1. Changing them mid-miss is undefined.
- Reset values: `busywait`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, and `readdata`=0 whenever there is no read hit. FSM is IDLE and all valid/dirty bits are 0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). The in-flight transfer is abandoned, and any dirty data is lost.

## Timing
- Read hit and write hit complete in 0 stall cycles. A write hit commits at the next posedge.
- Clean miss: FETCH (1 + memory busy cycles), then UPDATE (1 cycle), then the hit cycle.
- Dirty miss: WRITE_BACK (1 + memory busy cycles) is added before FETCH.
- `mem_read` and `mem_write` are never 1 simultaneously. Both change only on posedge or reset.

## Structure
- Shared package `dcache_pkg` holds:
  - the state enum {IDLE, WRITE_BACK, FETCH, UPDATE};
  - the width constants TAG_W, INDEX_W, OFFSET_W and BLOCK_W=32;
  - address-field slicing helpers.
- One sub-module, `dcache_ctrl`, holds the FSM and the memory-handshake outputs.
- Arrays, hit logic and byte select stay in `dcache`.

## Test plan
- Cold read miss: reset, then read 0x00 with memory all zero. Required: `busywait` 1, `mem_read` with `mem_address` 0x00, then UPDATE, then `readdata` 0x00, then `busywait` 0.
- Write-allocate then hit: write 0xAB to 0x05. This is a miss, so a fetch of block 0x01 occurs. Then read 0x05. Required: `readdata` 0xAB, `busywait` 0, no `mem_read`/`mem_write` pulses.
- Dirty eviction: after the previous scenario, read 0x25 (tag 1, index 1). Required:
  - first `mem_write`, `mem_address` 0x01, `mem_writedata` 0x0000AB00;
  - then `mem_read`, `mem_address` 0x09;
  - afterwards, read 0x05 misses again.
- Reset mid-FETCH: assert `reset` while `mem_read`=1. Required: `mem_read`, `busywait` and `mem_address` drop to 0 at once. A following read of a previously cached address misses.
- Illegal `read && write` on 0x05: required `busywait` 0, no memory traffic, and no change to cache contents.
